pmem_line_ctrl: RTL
===================

Name: pmem_line_ctrl

Overview:
Physical-memory-side responder for the cache's line interface. It accepts 128-bit line read and write requests from cache_control/datapath on the pmem_* handshake. Each line is serviced as 8 sequential 16-bit word transactions on a word-wide backing-store port, where this block acts as initiator. It sits between the cache and the word-wide memory, and is the other end of the cache's pmem protocol.

Parameters:
BEATS, 8, words per line; fixed at 8 for a 128-bit line.
WORD_W, 16, backing-store word width in bits.
ADDR_W, 16, byte-address width.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
pmem_address  in  16  line request byte address; bits [3:0] are ignored.
pmem_read  in  1  line read request; held by the cache until pmem_resp.
pmem_write  in  1  line write request; held by the cache until pmem_resp.
pmem_wdata  in  128  line write data; word k is bits [16k+15:16k].
pmem_rdata  out  128  line read data; valid when pmem_resp=1 after a read.
pmem_resp  out  1  one-cycle completion pulse.
ws_addr  out  16  word byte address: {line_base[15:4], beat, 1'b0}.
ws_read  out  1  word read request.
ws_write  out  1  word write request.
ws_wdata  out  16  word write data.
ws_rdata  in  16  word read data; sampled when ws_resp=1.
ws_resp  in  1  word completion from the backing store; may arrive in the same cycle as the request, or later.

Behaviour:
- Reset (asynchronous, active-high): state=s_idle, beat=0.
  - Line buffer and pmem_rdata are set to 0.
  - pmem_resp, ws_read and ws_write are 0; ws_addr and ws_wdata are 0.
- A reset asserted mid-operation aborts the transfer immediately. No pmem_resp is generated for the aborted request. After reset deasserts, a still-held request is re-accepted from beat 0.
- States: s_idle, s_read_beat, s_write_beat, s_gap, s_resp.
- s_idle:
  - If pmem_read=1, latch line_base=pmem_address[15:4], set beat=0, go to s_read_beat.
  - Else if pmem_write=1, also latch pmem_wdata into the line buffer, then go to s_write_beat.
  - If both requests are asserted (illegal), read wins.
- s_read_beat: ws_read=1, ws_addr = beat address.
  - Stay in this state until ws_resp=1.
  - On ws_resp, write ws_rdata into buffer slot[beat].
  - If beat==7, go to s_resp; else beat<=beat+1 and go to s_gap.
- s_write_beat: ws_write=1, ws_wdata=buffer slot[beat].
  - Same resp, beat-advance and beat==7 rules as s_read_beat.
- s_gap: ws_read and ws_write are 0 for exactly one cycle, then return to the beat state of the current operation.
- s_resp: pmem_resp=1 for exactly one cycle.
  - After a read, pmem_rdata = buffer.
  - Always go to s_idle next. A request still high in this cycle is not re-accepted.
- pmem_rdata holds the last completed read line until the next read completes. Writes do not alter pmem_rdata.
- Latency with zero-wait memory: request first seen in s_idle at cycle 0 → pmem_resp at cycle 16 (8 beats + 7 gaps). Each wait cycle of ws_resp adds 1.
- ws_read and ws_write are never both 1.
- ws_addr is stable for the whole of each beat.
- beat is 3 bits and never wraps past 7 within a line.

Decomposition:
- Add to the shared lc3b_types package:
  - lc3b_line (128-bit logic) and lc3b_word (16-bit).
  - Constant LINE_BEATS=8.
  - A state enum for this block is kept local to the module.
- One sub-module is natural: pmem_line_buffer.
  - 128-bit register.
  - Full-line load port and 16-bit slot write by 3-bit index.
  - Slot read mux.
  - Asynchronous clear.

Test Plan:
- Reset then idle: pulse reset mid-cycle with no requests → all outputs 0 asynchronously; ws_read and ws_write remain 0 for 20 cycles.
- Zero-wait read: pmem_address=0x1236, memory returns word = byte address.
  - ws_addr must sequence 0x1230,0x1232,…,0x123E with one gap between beats.
  - pmem_resp is a single pulse at cycle 16.
  - pmem_rdata=0x123E_123C_123A_1238_1236_1234_1232_1230.
- Wait-state write: pmem_address=0x4000, pmem_wdata=0x7777_6666_5555_4444_3333_2222_1111_0000, ws_resp delayed 2 cycles per beat.
  - ws_wdata per beat is 0x0000…0x7777.
  - pmem_resp at cycle 32.
  - pmem_rdata unchanged from the previous read.
- Request held through resp: keep pmem_read=1 for 3 cycles after pmem_resp → exactly one pmem_resp per accepted request, and a new read starts only from s_idle.
- Reset mid-line: assert reset during beat 4 of a read → ws_read drops in the same cycle and no pmem_resp is generated. Rerun the same read → correct line, full 16-cycle latency.
- Simultaneous pmem_read=1 and pmem_write=1: the operation is a read → ws_write stays 0 throughout.

Source files
------------

// File: rtl/pmem_line_ctrl_pkg.sv
// Shared LC-3b types used by the cache/memory line path.
package lc3b_types;
    localparam int LINE_BEATS = 8;
    localparam int WORD_BITS  = 16;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_word;
endpackage

// File: rtl/pmem_line_buffer.sv
// 128-bit line buffer: whole-line load, per-slot word write, and slot read mux.
module pmem_line_buffer
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [127:0] i_line,
    input  logic         i_wr_en,
    input  logic [2:0]   i_wr_idx,
    input  logic [15:0]  i_wr_word,
    input  logic [2:0]   i_rd_idx,
    output logic [15:0]  o_rd_word,
    output logic [127:0] o_line
);
    lc3b_line r_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else if (i_wr_en) begin
            r_line[{i_wr_idx, 4'b0000} +: WORD_BITS] <= i_wr_word;
        end
    end

    assign o_rd_word = r_line[{i_rd_idx, 4'b0000} +: WORD_BITS];
    assign o_line    = r_line;
endmodule

// File: rtl/pmem_line_ctrl.sv
// Line-to-word bridge: services 128-bit pmem line reads/writes as 8 word beats
// on the backing-store port, with one idle gap cycle between beats.
module pmem_line_ctrl
    import lc3b_types::*;
#(
    parameter int BEATS  = 8,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       pmem_address,
    input  logic                    pmem_read,
    input  logic                    pmem_write,
    input  logic [BEATS*WORD_W-1:0] pmem_wdata,
    output logic [BEATS*WORD_W-1:0] pmem_rdata,
    output logic                    pmem_resp,
    output logic [ADDR_W-1:0]       ws_addr,
    output logic                    ws_read,
    output logic                    ws_write,
    output logic [WORD_W-1:0]       ws_wdata,
    input  logic [WORD_W-1:0]       ws_rdata,
    input  logic                    ws_resp,
    output logic [2:0]              o_dbg_state
);
    // Word handshake: ws_read/ws_write is held with a stable ws_addr/ws_wdata
    // until ws_resp is seen at a clock edge; that edge completes the beat.
    typedef enum logic [2:0] {
        s_idle       = 3'd0,
        s_read_beat  = 3'd1,
        s_write_beat = 3'd2,
        s_gap        = 3'd3,
        s_resp       = 3'd4
    } state_t;

    state_t              r_state;
    logic [2:0]          r_beat;
    logic                r_is_read;
    logic [ADDR_W-5:0]   r_base;

    logic                w_buf_load;
    logic                w_buf_wr;
    logic [WORD_W-1:0]   w_rd_word;
    lc3b_line            w_line;
    logic                w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^pmem_address[3:0];
    assign w_buf_load = (r_state == s_idle) && !pmem_read && pmem_write;
    assign w_buf_wr   = (r_state == s_read_beat) && ws_resp;
    assign o_dbg_state = r_state;

    pmem_line_buffer u_buf (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_buf_load),
        .i_line    (pmem_wdata),
        .i_wr_en   (w_buf_wr),
        .i_wr_idx  (r_beat),
        .i_wr_word (ws_rdata),
        .i_rd_idx  (r_beat),
        .o_rd_word (w_rd_word),
        .o_line    (w_line)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= s_idle;
            r_beat     <= '0;
            r_is_read  <= 1'b0;
            r_base     <= '0;
            pmem_rdata <= '0;
            pmem_resp  <= 1'b0;
            ws_addr    <= '0;
            ws_read    <= 1'b0;
            ws_write   <= 1'b0;
            ws_wdata   <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (r_state)
                s_idle: begin
                    // Read has priority when both requests are raised.
                    if (pmem_read || pmem_write) begin
                        r_base    <= pmem_address[ADDR_W-1:4];
                        r_beat    <= '0;
                        r_is_read <= pmem_read;
                        ws_addr   <= {pmem_address[ADDR_W-1:4], 4'b0000};
                        ws_read   <= pmem_read;
                        ws_write  <= !pmem_read;
                        if (!pmem_read) ws_wdata <= pmem_wdata[WORD_W-1:0];
                        r_state   <= pmem_read ? s_read_beat : s_write_beat;
                    end
                end
                s_read_beat, s_write_beat: begin
                    if (ws_resp) begin
                        ws_read  <= 1'b0;
                        ws_write <= 1'b0;
                        if (r_beat == 3'd7) begin
                            pmem_resp <= 1'b1;
                            // Final word is still on ws_rdata, so merge it in here.
                            if (r_is_read) pmem_rdata <= {ws_rdata, w_line[111:0]};
                            r_state <= s_resp;
                        end else begin
                            r_beat  <= r_beat + 3'd1;
                            r_state <= s_gap;
                        end
                    end
                end
                s_gap: begin
                    ws_addr  <= {r_base, r_beat, 1'b0};
                    ws_read  <= r_is_read;
                    ws_write <= !r_is_read;
                    if (!r_is_read) ws_wdata <= w_rd_word;
                    r_state  <= r_is_read ? s_read_beat : s_write_beat;
                end
                s_resp: begin
                    r_state <= s_idle;
                end
                default: begin
                    r_state <= s_idle;
                end
            endcase
        end
    end
endmodule
